// File: rtl/hdmi_src_sched.sv
// hdmi_src_sched
// Frame-synchronous source scheduler for the HDMI output path (pclk domain).
// Decodes the menu control into a display source. The output mux is retargeted
// only on a vsync edge. Black frames are forced after each switch, so the sink
// never sees a torn or partial frame.
//
// Ports
//   pclk         in   pixel clock
//   rst          in   asynchronous, active-high reset
//   level        in   menu level (sys_clk domain, synchronized here)
//   cnt_level1   in   [1:0] sub-module index (sys_clk domain)
//   fft_confirm  in   osc view select, 1 = FFT (sys_clk domain)
//   i_vs         in   vsync from the display timing generator
//   src_sel      out  [1:0] 0 = sig_gen/menu, 1 = osc time, 2 = osc FFT
//   blank_en     out  forces rgb to black downstream
//   busy         out  switch pending or blanking in progress
//   switch_done  out  one-cycle pulse when the new source goes live
//
// state   | meaning
// RUN     | output source matches the accepted request
// WAIT_VS | new request accepted, waiting for the frame boundary
// BLANK   | new source selected, inserting black frames
module hdmi_src_sched #(
    parameter logic VS_POL       = 1'b1,
    parameter int   STABLE_CYC   = 1024,
    parameter int   BLANK_FRAMES = 2
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic       level,
    input  logic [1:0] cnt_level1,
    input  logic       fft_confirm,
    input  logic       i_vs,
    output logic [1:0] src_sel,
    output logic       blank_en,
    output logic       busy,
    output logic       switch_done
);

    localparam int CW = $clog2(STABLE_CYC + 1);
    localparam int FW = (BLANK_FRAMES > 0) ? $clog2(BLANK_FRAMES + 1) : 1;

    localparam logic [CW-1:0] C_STABLE_MAX  = CW'(STABLE_CYC);
    localparam logic [CW-1:0] C_STABLE_LAST = CW'(STABLE_CYC - 1);
    localparam logic [FW-1:0] C_FRAMES      = FW'(BLANK_FRAMES);
    localparam logic [FW-1:0] C_FRAME_ONE   = FW'(1);

    localparam logic [1:0] S_RUN     = 2'd0;
    localparam logic [1:0] S_WAIT_VS = 2'd1;
    localparam logic [1:0] S_BLANK   = 2'd2;

    // Synchronizers. The cnt_level1 bits are synchronized independently. Any
    // bit skew shows up as a short-lived request, and the stability filter
    // rejects it.
    logic [1:0] r_lvl_sync;
    logic [1:0] r_fft_sync;
    logic [1:0] r_cnt_sync1;
    logic [1:0] r_cnt_sync2;

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            r_lvl_sync  <= 2'b00;
            r_fft_sync  <= 2'b00;
            r_cnt_sync1 <= 2'b00;
            r_cnt_sync2 <= 2'b00;
        end else begin
            r_lvl_sync  <= {r_lvl_sync[0], level};
            r_fft_sync  <= {r_fft_sync[0], fft_confirm};
            r_cnt_sync1 <= cnt_level1;
            r_cnt_sync2 <= r_cnt_sync1;
        end
    end

    logic [1:0] w_req;

    always_comb begin
        w_req = 2'd0;
        if ({r_lvl_sync[1], r_cnt_sync2} == 3'b101) begin
            w_req = r_fft_sync[1] ? 2'd2 : 2'd1;
        end
    end

    // Stability filter. r_req_q holds the previous cycle's request. The
    // accepted value is loaded on the same edge on which the counter reaches
    // its saturation value.
    logic [1:0]    r_req_q;
    logic [CW-1:0] r_stab_cnt;
    logic [1:0]    r_stable_req;

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            r_req_q      <= 2'd0;
            r_stab_cnt   <= '0;
            r_stable_req <= 2'd0;
        end else begin
            r_req_q <= w_req;
            if (w_req != r_req_q) begin
                r_stab_cnt <= '0;
            end else if (r_stab_cnt != C_STABLE_MAX) begin
                r_stab_cnt <= r_stab_cnt + 1'b1;
                if (r_stab_cnt == C_STABLE_LAST) begin
                    r_stable_req <= w_req;
                end
            end
        end
    end

    logic r_vs_q;
    logic r_vs_qq;
    logic w_vs_edge;

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            r_vs_q  <= ~VS_POL;
            r_vs_qq <= ~VS_POL;
        end else begin
            r_vs_q  <= i_vs;
            r_vs_qq <= r_vs_q;
        end
    end

    assign w_vs_edge = (r_vs_q == VS_POL) && (r_vs_qq != VS_POL);

    logic [1:0]    r_state;
    logic [1:0]    r_target;
    logic [FW-1:0] r_fcnt;

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            r_state     <= S_RUN;
            r_target    <= 2'd0;
            r_fcnt      <= '0;
            src_sel     <= 2'd0;
            blank_en    <= 1'b0;
            switch_done <= 1'b0;
        end else begin
            switch_done <= 1'b0;
            case (r_state)
                S_RUN: begin
                    if (r_stable_req != src_sel) begin
                        r_target <= r_stable_req;
                        r_state  <= S_WAIT_VS;
                    end
                end
                S_WAIT_VS: begin
                    r_target <= r_stable_req;
                    if (r_stable_req == src_sel) begin
                        r_state <= S_RUN;
                    end else if (w_vs_edge) begin
                        src_sel <= r_target;
                        if (BLANK_FRAMES > 0) begin
                            blank_en <= 1'b1;
                            r_fcnt   <= C_FRAMES;
                            r_state  <= S_BLANK;
                        end else begin
                            switch_done <= 1'b1;
                            r_state     <= S_RUN;
                        end
                    end
                end
                S_BLANK: begin
                    // r_target follows the accepted request. If it differs
                    // from src_sel at a frame edge, the request was superseded,
                    // so retarget and restart blanking.
                    r_target <= r_stable_req;
                    if (w_vs_edge) begin
                        if (r_target != src_sel) begin
                            src_sel <= r_target;
                            r_fcnt  <= C_FRAMES;
                        end else if (r_fcnt == C_FRAME_ONE) begin
                            r_fcnt      <= '0;
                            blank_en    <= 1'b0;
                            switch_done <= 1'b1;
                            r_state     <= S_RUN;
                        end else begin
                            r_fcnt <= r_fcnt - 1'b1;
                        end
                    end
                end
                default: begin
                    r_state  <= S_RUN;
                    blank_en <= 1'b0;
                end
            endcase
        end
    end

    assign busy = (r_state != S_RUN);

endmodule

// File: tb/tb_hdmi_src_sched.sv
// tb_hdmi_src_sched
// Bench for hdmi_src_sched. The reference model tracks the display source at
// frame level. The accepted request is the decode of the inputs after they
// have held long enough. Each vsync edge then switches the source, restarts
// blanking, or counts down blanking. Checks are made at quiet points, away
// from any in-flight transition.
module tb_hdmi_src_sched;

    localparam int STABLE_CYC   = 1024;
    localparam int BLANK_FRAMES = 2;

    logic       pclk = 1'b0;
    logic       rst = 1'b1;
    logic       level = 1'b0;
    logic [1:0] cnt_level1 = 2'b00;
    logic       fft_confirm = 1'b0;
    logic       i_vs = 1'b0;
    logic [1:0] src_sel;
    logic       blank_en;
    logic       busy;
    logic       switch_done;

    hdmi_src_sched #(
        .VS_POL      (1'b1),
        .STABLE_CYC  (STABLE_CYC),
        .BLANK_FRAMES(BLANK_FRAMES)
    ) dut (
        .pclk       (pclk),
        .rst        (rst),
        .level      (level),
        .cnt_level1 (cnt_level1),
        .fft_confirm(fft_confirm),
        .i_vs       (i_vs),
        .src_sel    (src_sel),
        .blank_en   (blank_en),
        .busy       (busy),
        .switch_done(switch_done)
    );

    always #5 pclk = ~pclk;

    int n_checks = 0;
    int n_errors = 0;
    int n_done_seen = 0;

    int m_src = 0;
    int m_req = 0;
    int m_blank = 0;
    int m_fcnt = 0;
    int m_done = 0;

    always @(posedge pclk) begin
        if (switch_done === 1'b1) n_done_seen <= n_done_seen + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic int decode(input logic l, input logic [1:0] c, input logic f);
        if ({l, c} == 3'b101) return f ? 2 : 1;
        return 0;
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".src"}, 32'(src_sel), 32'(m_src));
        check({tag, ".blank"}, 32'(blank_en), 32'(m_blank));
        check({tag, ".busy"}, 32'(busy), 32'((m_blank != 0) || (m_req != m_src)));
        check({tag, ".done"}, 32'(n_done_seen), 32'(m_done));
    endtask

    task automatic model_vs();
        if (m_blank != 0) begin
            if (m_req != m_src) begin
                m_src  = m_req;
                m_fcnt = BLANK_FRAMES;
            end else begin
                m_fcnt--;
                if (m_fcnt == 0) begin
                    m_blank = 0;
                    m_done++;
                end
            end
        end else if (m_req != m_src) begin
            m_src   = m_req;
            m_blank = 1;
            m_fcnt  = BLANK_FRAMES;
        end
    endtask

    task automatic vs_pulse();
        @(negedge pclk) i_vs = 1'b1;
        repeat (4) @(negedge pclk);
        i_vs = 1'b0;
        repeat (8) @(negedge pclk);
        model_vs();
    endtask

    task automatic apply(input logic l, input logic [1:0] c, input logic f);
        @(negedge pclk);
        level = l;
        cnt_level1 = c;
        fft_confirm = f;
        repeat (STABLE_CYC + 20) @(negedge pclk);
        m_req = decode(l, c, f);
    endtask

    task automatic rand_in(output logic l, output logic [1:0] c, output logic f);
        int r;
        r = $urandom_range(0, 2);
        f = 1'($urandom_range(0, 1));
        if (r == 0) begin
            l = 1'($urandom_range(0, 1));
            c = 2'($urandom_range(0, 3));
            if ({l, c} == 3'b101) l = 1'b0;
        end else begin
            l = 1'b1;
            c = 2'b01;
            f = (r == 2);
        end
    endtask

    task automatic model_reset();
        m_src = 0;
        m_req = 0;
        m_blank = 0;
        m_fcnt = 0;
    endtask

    initial begin
        logic       l;
        logic [1:0] c;
        logic       f;
        logic       sl;
        logic [1:0] sc;
        logic       sf;

        repeat (3) @(negedge pclk);
        rst = 1'b0;
        @(negedge pclk);
        check_all("reset");

        // 1: request osc time, no vsync
        level = 1'b1; cnt_level1 = 2'b01; fft_confirm = 1'b0;
        repeat (1000) @(negedge pclk);
        check("t1.busy_early", 32'(busy), 32'd0);
        repeat (40) @(negedge pclk);
        check("t1.busy_late", 32'(busy), 32'd1);
        repeat (960) @(negedge pclk);
        m_req = 1;
        check_all("t1.end");

        // 2: three frame edges complete the switch
        for (int i = 1; i <= 3; i++) begin
            vs_pulse();
            check_all($sformatf("t2.edge%0d", i));
        end

        // 3: a request toggling faster than the filter never switches
        for (int i = 0; i < 6; i++) begin
            fft_confirm = ~fft_confirm;
            for (int k = 0; k < 5; k++) begin
                repeat (100) @(negedge pclk);
                check("t3.src", 32'(src_sel), 32'(m_src));
                check("t3.busy", 32'(busy), 32'd0);
                check("t3.blank", 32'(blank_en), 32'd0);
            end
        end
        vs_pulse();
        check_all("t3.end");

        // 4: retarget during blanking
        apply(1'b0, 2'b00, 1'b0);
        vs_pulse();
        repeat (2) vs_pulse();
        check_all("t4.at0");
        apply(1'b1, 2'b01, 1'b0);
        vs_pulse();
        check_all("t4.blank1");
        apply(1'b1, 2'b01, 1'b1);
        check_all("t4.pending");
        for (int i = 1; i <= 3; i++) begin
            vs_pulse();
            check_all($sformatf("t4.edge%0d", i));
        end
        check("t4.src_fft", 32'(src_sel), 32'd2);

        // 5: request withdrawn before any frame edge
        apply(1'b0, 2'b11, 1'b1);
        check_all("t5.wait");
        apply(1'b1, 2'b01, 1'b1);
        check_all("t5.back");

        // 6: reset mid-blank, then a normal switch
        apply(1'b1, 2'b01, 1'b0);
        vs_pulse();
        check_all("t6.blank");
        @(negedge pclk);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all("t6.rst");
        @(negedge pclk) rst = 1'b0;
        @(negedge pclk);
        check_all("t6.release");
        apply(1'b1, 2'b01, 1'b0);
        check_all("t6.pending");
        repeat (3) vs_pulse();
        check_all("t6.done");

        // Random sequence of requests, glitches and frame edges
        for (int it = 0; it < 30; it++) begin
            case ($urandom_range(0, 3))
                0: begin
                    rand_in(l, c, f);
                    apply(l, c, f);
                end
                1: begin
                    sl = level; sc = cnt_level1; sf = fft_confirm;
                    rand_in(l, c, f);
                    @(negedge pclk);
                    level = l; cnt_level1 = c; fft_confirm = f;
                    repeat ($urandom_range(10, 500)) @(negedge pclk);
                    level = sl; cnt_level1 = sc; fft_confirm = sf;
                    repeat (5) @(negedge pclk);
                end
                default: vs_pulse();
            endcase
            check_all($sformatf("rnd%0d", it));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
